// File: rtl/ysyx_23060184_clint_axil.sv
// CLINT behind an AXI4-Lite slave: per-hart msip/mtimecmp and a shared 64-bit mtime.
// Ports: clk/resetn, AXI-Lite AW/W/B/AR/R channels, per-hart mtip and msip outputs.
module ysyx_23060184_clint_axil #(
  parameter int NHART  = 1,
  parameter int DIV    = 1,
  parameter int AXI_AW = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [AXI_AW-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [AXI_AW-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic [NHART-1:0]  mtip,
  output logic [NHART-1:0]  msip
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(DIV - 1);
  localparam logic [13:0] NH_MSIP = 14'(NHART);
  localparam logic [12:0] NH_CMP  = 13'(NHART);

  typedef enum logic [1:0] {
    K_ERR, K_MSIP, K_CMP, K_TIME
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [2:0] hart;
    logic       hi;
  } dec_t;

  function automatic dec_t decode(input logic [15:0] a);
    dec_t d;
    logic [12:0] rel;
    d.kind = K_ERR;
    d.hart = a[4:2];
    d.hi   = 1'b0;
    // word offset from 0x4000 in 8-byte units
    rel = a[15:3] - 13'h0800;
    if (a[1:0] == 2'b00) begin
      if (a[15:2] < NH_MSIP) begin
        d.kind = K_MSIP;
      end else if (a[15:14] == 2'b01 && rel < NH_CMP) begin
        d.kind = K_CMP;
        d.hart = rel[2:0];
        d.hi   = a[2];
      end else if (a[15:3] == 13'h17FF) begin
        d.kind = K_TIME;
        d.hi   = a[2];
      end
    end
    return d;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  logic [PW-1:0] presc;
  logic          tick;
  logic [63:0]   mtime;
  logic [63:0]   mtime_nxt;
  logic [63:0]   cmp [NHART];

  logic          aw_held;
  logic          w_held;
  logic [15:0]   aw_addr;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;
  logic          commit;
  dec_t          wdec;
  dec_t          rdec;
  logic [31:0]   rd_val;

  assign tick    = (presc == PLAST);
  assign commit  = aw_held && w_held;
  assign wdec    = decode(aw_addr);
  assign rdec    = decode(araddr[15:0]);
  assign awready = !aw_held && !bvalid;
  assign wready  = !w_held && !bvalid;
  assign arready = !rvalid;

  if (AXI_AW > 16) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{awaddr[AXI_AW-1:16], araddr[AXI_AW-1:16]};
  end

  // A write to one half replaces the tick: no increment, no carry.
  always_comb begin
    mtime_nxt = mtime + {63'd0, tick};
    if (commit && wdec.kind == K_TIME) begin
      if (wdec.hi) begin
        mtime_nxt = {merge(mtime[63:32], w_data, w_strb), mtime[31:0]};
      end else begin
        mtime_nxt = {mtime[63:32], merge(mtime[31:0], w_data, w_strb)};
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (rdec.kind)
      K_MSIP: begin
        for (int h = 0; h < NHART; h++) begin
          if (rdec.hart == 3'(h)) rd_val = {31'd0, msip[h]};
        end
      end
      K_CMP: begin
        for (int h = 0; h < NHART; h++) begin
          if (rdec.hart == 3'(h)) begin
            rd_val = rdec.hi ? cmp[h][63:32] : cmp[h][31:0];
          end
        end
      end
      K_TIME:  rd_val = rdec.hi ? mtime[63:32] : mtime[31:0];
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc   <= '0;
      mtime   <= '0;
      msip    <= '0;
      mtip    <= '0;
      for (int h = 0; h < NHART; h++) cmp[h] <= '1;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= 2'b00;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      mtime <= mtime_nxt;
      for (int h = 0; h < NHART; h++) mtip[h] <= (mtime >= cmp[h]);

      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
        rresp  <= (rdec.kind == K_ERR) ? 2'b10 : 2'b00;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end

      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= (wdec.kind == K_ERR) ? 2'b10 : 2'b00;
        for (int h = 0; h < NHART; h++) begin
          if (wdec.hart == 3'(h)) begin
            if (wdec.kind == K_MSIP && w_strb[0]) msip[h] <= w_data[0];
            if (wdec.kind == K_CMP) begin
              if (wdec.hi) begin
                cmp[h][63:32] <= merge(cmp[h][63:32], w_data, w_strb);
              end else begin
                cmp[h][31:0] <= merge(cmp[h][31:0], w_data, w_strb);
              end
            end
          end
        end
      end else begin
        if (bvalid && bready) bvalid <= 1'b0;
        if (awvalid && awready) begin
          aw_held <= 1'b1;
          aw_addr <= awaddr[15:0];
        end
        if (wvalid && wready) begin
          w_held <= 1'b1;
          w_data <= wdata;
          w_strb <= wstrb;
        end
      end
    end
  end

endmodule

// File: doc/ysyx_23060184_clint_axil.md
YSYX_23060184_CLINT_AXIL -- requirements
Module: ysyx_23060184_clint_axil

Interface
REQ-001 The block SHALL expose parameter NHART, default 1, number of harts (1..8) with private msip/mtimecmp.
REQ-002 The block SHALL expose parameter DIV, default 1, mtime tick period in clk cycles (>=1).
REQ-003 The block SHALL expose parameter AXI_AW, default 32, AXI address width; only bits [15:0] are decoded.
REQ-004 The port clk SHALL be an input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The port resetn SHALL be an input, 1 bit: synchronous, active-low reset.
REQ-006 The port awaddr SHALL be an input, AXI_AW bits: write address.
REQ-007 The port awvalid SHALL be an input, 1 bit; awready SHALL be an output, 1 bit.
REQ-008 The port wdata SHALL be an input, 32 bits: write data.
REQ-009 The port wstrb SHALL be an input, 4 bits: byte enables.
REQ-010 The port wvalid SHALL be an input, 1 bit; wready SHALL be an output, 1 bit.
REQ-011 The port bresp SHALL be an output, 2 bits; bvalid SHALL be an output, 1 bit; bready SHALL be an input, 1 bit.
REQ-012 The port araddr SHALL be an input, AXI_AW bits: read address.
REQ-013 The port arvalid SHALL be an input, 1 bit; arready SHALL be an output, 1 bit.
REQ-014 The port rdata SHALL be an output, 32 bits; rresp SHALL be an output, 2 bits.
REQ-015 The port rvalid SHALL be an output, 1 bit; rready SHALL be an input, 1 bit.
REQ-016 The port mtip SHALL be an output, NHART bits: per-hart timer interrupt.
REQ-017 The port msip SHALL be an output, NHART bits: per-hart software interrupt.

Function
REQ-018 The register map SHALL be: msip[h] at 0x0000+4h (bit 0 only, others read 0); mtimecmp[h] lo/hi at 0x4000+8h / +4; mtime lo/hi at 0xBFF8 / 0xBFFC.
REQ-019 mtime (64-bit) SHALL increment by 1 when a prescaler counter reaches DIV-1, then the counter returns to 0; DIV=1 means increment every cycle; it SHALL wrap 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-020 A bus write to either mtime half SHALL take priority over that cycle's increment; the other half SHALL keep its pre-write value and no carry is applied that cycle.
REQ-021 mtip[h] SHALL be registered: mtip[h] = (mtime >= mtimecmp[h]), unsigned 64-bit compare, visible one cycle after the operands change.
REQ-022 Read channel: arready=1 while no read response is pending; on arvalid&&arready the address is decoded and rvalid rises the next cycle with rdata/rresp held stable until rvalid&&rready; arready=0 while rvalid=1.
REQ-023 Write channel: awready and wready SHALL each be 1 until its beat is captured, independently, in any order or the same cycle; both stay 0 while a captured beat waits for its partner or bvalid=1.
REQ-024 When both AW and W are captured, the write SHALL commit on the next edge with wstrb byte masking, and bvalid SHALL rise that cycle and hold until bvalid&&bready.
REQ-025 Unmapped offset, hart index >= NHART, or addr[1:0]!=0 SHALL return resp 2'b10 (SLVERR), rdata 0, and no state change; mapped accesses SHALL return 2'b00.
REQ-026 A read and a write of the same register in the same cycle SHALL return the pre-write value.

Reset
REQ-027 On resetn=0 at a clk edge: mtime=0, prescaler=0, msip=0, every mtimecmp=all ones, mtip=0, bvalid=rvalid=0, rdata=0, resp=00, captured AW/W discarded; awready=wready=arready=1 from the first cycle after resetn returns high.
REQ-028 Reset asserted mid-transaction SHALL abort it silently: no response is issued and no partial write commits.

Verification
REQ-029 Reset: hold resetn low 2 cycles with arvalid=1 -> rvalid=0, mtip=0, msip=0; reading mtime lo immediately after release returns <= 2.
REQ-030 Timer: DIV=1, write mtimecmp0 hi=0 then lo=0x40 -> mtip[0]=1 exactly one cycle after mtime==0x40; writing hi=0xFFFFFFFF clears mtip[0] one cycle later.
REQ-031 Wrap and carry: write mtime hi=0, lo=0xFFFFFFFF with DIV=4 -> after 4 cycles lo=0, hi=1.
REQ-032 Ordering: NHART=2, W (0x1, wstrb 0xF) 3 cycles before AW to 0x0004 -> exactly one B with bresp=00 and msip=2'b10.
REQ-033 Errors/backpressure: read 0x8000 with rready held low 5 cycles -> rvalid stays 1, rresp=10, rdata=0 throughout, arready=0 until the handshake completes.
REQ-034 Byte strobe: mtimecmp0 lo=0xFFFFFFFF, write 0xAABBCCDD with wstrb=0001 -> readback 0xFFFFFFDD.
